secded_dec128: RTL and testbench

//  Pipelined SECDED (Hamming + overall parity) decoder for 128-bit words: receive end of the

---
 rtl/secded_pkg.sv | 52 +++++
 rtl/secded_syndrome.sv | 19 +
 rtl/secded_dec128.sv | 146 ++++++++++++++
 tb/tb_secded_dec128.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/secded_pkg.sv
// rtl/secded_pkg.sv - SECDED 128-bit shared constants, status enum, layout map and encoder
package secded_pkg;

    localparam int DATA_W  = 128;
    localparam int PAR_W   = 8;
    localparam int CODE_W  = DATA_W + PAR_W + 1;
    localparam int DIDX_W  = $clog2(DATA_W);
    localparam int CIDX_W  = $clog2(CODE_W);

    typedef enum logic [1:0] {
        CLEAN         = 2'd0,
        CORRECTED     = 2'd1,
        UNCORRECTABLE = 2'd2
    } status_e;

    function automatic logic is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    // Codeword position holding data bit idx (data fills non-power-of-two positions upward)
    function automatic int data_pos(input int idx);
        int n;
        data_pos = 0;
        n = 0;
        for (int p = 3; p < CODE_W; p++) begin
            if (!is_pow2(p)) begin
                if (n == idx) data_pos = p;
                n++;
            end
        end
    endfunction

    function automatic logic [CODE_W-1:0] secded_encode(input logic [DATA_W-1:0] data);
        logic [CODE_W-1:0] code;
        logic [PAR_W-1:0]  syn;
        int                j;
        code = '0;
        syn  = '0;
        j    = 0;
        for (int p = 1; p < CODE_W; p++) begin
            if (!is_pow2(p)) begin
                code[CIDX_W'(p)] = data[DIDX_W'(j)];
                if (data[DIDX_W'(j)]) syn = syn ^ PAR_W'(p);
                j++;
            end
        end
        for (int k = 0; k < PAR_W; k++) code[CIDX_W'(1 << k)] = syn[k];
        code[0] = ^code[CODE_W-1:1];
        return code;
    endfunction

endpackage

// File: rtl/secded_syndrome.sv
// rtl/secded_syndrome.sv - combinational Hamming syndrome and overall parity of a codeword
module secded_syndrome
    import secded_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [PAR_W-1:0]  syn_o,
    output logic              par_o
);

    always_comb begin
        syn_o = '0;
        for (int p = 1; p < CODE_W; p++) begin
            if (code_i[CIDX_W'(p)]) syn_o = syn_o ^ PAR_W'(p);
        end
    end

    assign par_o = ^code_i;

endmodule

// File: rtl/secded_dec128.sv
// rtl/secded_dec128.sv - 2-stage SECDED decoder with saturating error counters
// Optional error log (err_flag/err_syndrome) enabled by SECDED_DEC_ERR_LOG_EN.
module secded_dec128 #(
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W+8:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_status,
`ifdef SECDED_DEC_ERR_LOG_EN
    output logic              err_flag,
    output logic [7:0]        err_syndrome,
`endif
    input  logic              cnt_clear,
    output logic [CNT_W-1:0]  corr_count,
    output logic [CNT_W-1:0]  uncorr_count
);
    import secded_pkg::*;

    logic              s1_valid_q, s2_valid_q;
    logic [CODE_W-1:0] s1_code_q;
    logic [PAR_W-1:0]  s1_syn_q;
    logic              s1_par_q;
    logic [DATA_W-1:0] s2_data_q;
    status_e           s2_status_q;
    logic [CNT_W-1:0]  corr_q, uncorr_q;

    logic [PAR_W-1:0]  syn_d;
    logic              par_d;
    logic [CODE_W-1:0] flip_mask, fixed_code;
    logic [DATA_W-1:0] data_d;
    status_e           status_d;
    logic              advance, out_fire;

    // The whole pipe moves together; it only stalls when a finished word is refused.
    assign advance  = !s2_valid_q || out_ready;
    assign out_fire = s2_valid_q && out_ready;

    secded_syndrome u_syndrome (
        .code_i (in_code),
        .syn_o  (syn_d),
        .par_o  (par_d)
    );

    always_comb begin
        flip_mask = '0;
        status_d  = CLEAN;
        if (s1_par_q) begin
            if (s1_syn_q > PAR_W'(CODE_W - 1)) begin
                status_d = UNCORRECTABLE;
            end else begin
                status_d  = CORRECTED;
                flip_mask = {{(CODE_W-1){1'b0}}, 1'b1} << s1_syn_q;
            end
        end else if (s1_syn_q != '0) begin
            status_d = UNCORRECTABLE;
        end
    end

    // Mask stays zero for uncorrectable words, so their data comes through raw.
    assign fixed_code = s1_code_q ^ flip_mask;

    for (genvar i = 0; i < DATA_W; i++) begin : g_extract
        localparam int POS = data_pos(i);
        assign data_d[i] = fixed_code[POS];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_code_q   <= '0;
            s1_syn_q    <= '0;
            s1_par_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_status_q <= CLEAN;
        end else if (advance) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_code_q <= in_code;
                s1_syn_q  <= syn_d;
                s1_par_q  <= par_d;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q   <= data_d;
                s2_status_q <= status_d;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            corr_q   <= '0;
            uncorr_q <= '0;
        end else if (cnt_clear) begin
            corr_q   <= '0;
            uncorr_q <= '0;
        end else if (out_fire) begin
            if (s2_status_q == CORRECTED && corr_q != '1)
                corr_q <= corr_q + CNT_W'(1);
            if (s2_status_q == UNCORRECTABLE && uncorr_q != '1)
                uncorr_q <= uncorr_q + CNT_W'(1);
        end
    end

`ifdef SECDED_DEC_ERR_LOG_EN
    logic [PAR_W-1:0] s2_syn_q;
    logic             err_flag_q;
    logic [7:0]       err_syn_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s2_syn_q   <= '0;
            err_flag_q <= 1'b0;
            err_syn_q  <= '0;
        end else begin
            if (advance && s1_valid_q) s2_syn_q <= s1_syn_q;
            if (cnt_clear) begin
                err_flag_q <= 1'b0;
                err_syn_q  <= '0;
            end else if (out_fire && s2_status_q == UNCORRECTABLE && !err_flag_q) begin
                err_flag_q <= 1'b1;
                err_syn_q  <= s2_syn_q;
            end
        end
    end

    assign err_flag     = err_flag_q;
    assign err_syndrome = err_syn_q;
`endif

    assign in_ready     = advance;
    assign out_valid    = s2_valid_q;
    assign out_data     = s2_data_q;
    assign out_status   = s2_status_q;
    assign corr_count   = corr_q;
    assign uncorr_count = uncorr_q;

endmodule

// File: tb/tb_secded_dec128.sv
// tb/tb_secded_dec128.sv - directed self-checking bench for secded_dec128
`timescale 1ns/1ps
module tb_secded_dec128;
    import secded_pkg::*;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid, in_ready, out_valid, out_ready, cnt_clear;
    logic [CODE_W-1:0] in_code;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_status;
    logic [15:0]       corr_count, uncorr_count;
`ifdef SECDED_DEC_ERR_LOG_EN
    logic              err_flag;
    logic [7:0]        err_syndrome;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_rx     = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [1:0]        status;
    } exp_t;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    secded_dec128 dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_code      (in_code),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_status   (out_status),
`ifdef SECDED_DEC_ERR_LOG_EN
        .err_flag     (err_flag),
        .err_syndrome (err_syndrome),
`endif
        .cnt_clear    (cnt_clear),
        .corr_count   (corr_count),
        .uncorr_count (uncorr_count)
    );

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [CODE_W-1:0] flip(input logic [CODE_W-1:0] c, input int p);
        return c ^ ({{(CODE_W-1){1'b0}}, 1'b1} << p);
    endfunction

    // Output monitor: scoreboard order plus hold-while-stalled
    logic              stall_seen = 1'b0;
    logic [DATA_W-1:0] held_data;
    logic [1:0]        held_status;
    exp_t              e;
    always @(negedge clock) begin
        if (reset) begin
            if (stall_seen && out_valid) begin
                check_eq("stall_data", out_data, held_data);
                check_eq("stall_status", out_status, held_status);
            end
            if (out_valid && out_ready) begin
                n_rx++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("out_data", out_data, e.data);
                    check_eq("out_status", out_status, e.status);
                end
            end
            stall_seen  = out_valid && !out_ready;
            held_data   = out_data;
            held_status = out_status;
        end else begin
            stall_seen = 1'b0;
        end
    end

    task automatic send(input logic [CODE_W-1:0] c, input logic [DATA_W-1:0] d, input logic [1:0] s);
        int guard = 0;
        in_code  = c;
        in_valid = 1'b1;
        while (!in_ready && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (!in_ready) check_eq("send_timeout", 0, 1);
        else exp_q.push_back('{d, s});
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(negedge clock);
            guard++;
        end
        if (exp_q.size() != 0) check_eq("drain_timeout", exp_q.size(), 0);
        @(negedge clock);
    endtask

    logic [CODE_W-1:0] c, c5;
    logic [DATA_W-1:0] d;
    localparam logic [DATA_W-1:0] DA = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [DATA_W-1:0] DB = 128'hDEADBEEFCAFEF00D5555AAAA12345678;
    int rx0;

    initial begin
        in_valid  = 1'b0;
        in_code   = '0;
        out_ready = 1'b1;
        cnt_clear = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;

        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_status", out_status, 0);
        check_eq("rst_corr", corr_count, 0);
        check_eq("rst_uncorr", uncorr_count, 0);
`ifdef SECDED_DEC_ERR_LOG_EN
        check_eq("rst_err_flag", err_flag, 0);
        check_eq("rst_err_syn", err_syndrome, 0);
`endif
        c = secded_encode(128'h1);
        check_eq("enc_one", c[127:0], 128'hF);

        // 1: clean words with latency
        d = '0;
        send(secded_encode(d), d, CLEAN);
        check_eq("t1_lat1_zero", out_valid, 0);
        @(negedge clock);
        check_eq("t1_lat2_zero", out_valid, 1);
        drain();
        d = '1;
        send(secded_encode(d), d, CLEAN);
        check_eq("t1_lat1_ones", out_valid, 0);
        @(negedge clock);
        check_eq("t1_lat2_ones", out_valid, 1);
        check_eq("t1_data_ones", out_data, d);
        drain();
        check_eq("t1_corr", corr_count, 0);

        // 2: single data-bit error
        send(flip(secded_encode(DA), 77), DA, CORRECTED);
        drain();
        check_eq("t2_corr", corr_count, 1);

        // 3: parity-bit-only, top position, double and out-of-range syndromes
        send(flip(secded_encode(DB), 0), DB, CORRECTED);
        send(flip(secded_encode(DB), 136), DB, CORRECTED);
        drain();
        check_eq("t3_corr", corr_count, 3);
        send(flip(flip(secded_encode(DA), 5), 90), DA ^ (128'h1 << 1) ^ (128'h1 << 82), UNCORRECTABLE);
        drain();
        check_eq("t3_uncorr", uncorr_count, 1);
`ifdef SECDED_DEC_ERR_LOG_EN
        check_eq("t3_err_flag", err_flag, 1);
        check_eq("t3_err_syn", err_syndrome, 8'd95);
`endif
        send(flip(flip(secded_encode(DA), 3), 4), DA ^ 128'h1, UNCORRECTABLE);
        send(flip(flip(flip(secded_encode(DB), 128), 8), 4), DB, UNCORRECTABLE);
        drain();
        check_eq("t3_uncorr3", uncorr_count, 3);
`ifdef SECDED_DEC_ERR_LOG_EN
        check_eq("t3_err_syn_held", err_syndrome, 8'd95);
`endif

        // 4: stream under backpressure 1,0,0,...
        rx0 = n_rx;
        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    @(posedge clock);
                    #1 out_ready = (k % 3 == 0);
                end
                @(posedge clock);
                #1 out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    d = {4{32'((i + 1) * 32'h1111_1111)}};
                    c = secded_encode(d);
                    if (i % 3 == 1) send(flip(c, 3 + i * 12), d, CORRECTED);
                    else if (i % 3 == 2) send(flip(c, 0), d, CORRECTED);
                    else send(c, d, CLEAN);
                end
            end
        join
        drain();
        check_eq("t4_rx_count", n_rx - rx0, 10);
        check_eq("t4_corr", corr_count, 9);

        // 5: saturation and clear-wins
        cnt_clear = 1'b1;
        @(negedge clock);
        cnt_clear = 1'b0;
        check_eq("t5_clr_corr", corr_count, 0);
        check_eq("t5_clr_uncorr", uncorr_count, 0);
`ifdef SECDED_DEC_ERR_LOG_EN
        check_eq("t5_clr_err_flag", err_flag, 0);
`endif
        c5 = flip(secded_encode(DB), 40);
        for (int i = 0; i < 65536; i++) send(c5, DB, CORRECTED);
        drain();
        check_eq("t5_sat", corr_count, 16'hFFFF);
        send(c5, DB, CORRECTED);
        @(negedge clock);
        check_eq("t5_pre_clr_valid", out_valid, 1);
        cnt_clear = 1'b1;
        @(negedge clock);
        cnt_clear = 1'b0;
        check_eq("t5_clr_wins", corr_count, 0);

        // 6: reset with two words in flight
        send(c5, DB, CORRECTED);
        drain();
        check_eq("t6_pre_corr", corr_count, 1);
        send(secded_encode(DA), DA, CLEAN);
        send(secded_encode(DB), DB, CLEAN);
        reset = 1'b0;
        #1;
        exp_q.delete();
        check_eq("t6_rst_valid", out_valid, 0);
        check_eq("t6_rst_corr", corr_count, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_eq("t6_no_partial", out_valid, 0);
        check_eq("t6_in_ready", in_ready, 1);
        send(secded_encode(DB), DB, CLEAN);
        check_eq("t6_lat1", out_valid, 0);
        @(negedge clock);
        check_eq("t6_lat2", out_valid, 1);
        drain();
        check_eq("t6_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
